pulse_period_monitor: RTL and testbench
=======================================

Name: pulse_period_monitor

Overview:
- Sits directly downstream of the periodic timer and consumes its one-cycle `pulse` output.
- Measures the interval between pulses and checks it against an expected period with a tolerance.
- Declares lock after a run of consecutive good intervals.
- Flags early pulses and missing (timed-out) pulses as one-cycle error strobes, with a saturating error tally for status readback.

Parameters:
- PERIOD, 12: expected pulse interval in clock cycles (the timer's default cadence).
- TOL, 0: allowed deviation in cycles. Window is [PERIOD-TOL, PERIOD+TOL]. Constraint: TOL < PERIOD.
- LOCK_COUNT, 3: consecutive in-window intervals required to lock. Constraint: >= 1.
- CNT_W, 8: width of the interval counter and `last_period`. Constraint: PERIOD+TOL+1 < 2^CNT_W.

Ports:
- clock, input, 1: system clock, rising edge.
- reset, input, 1: synchronous, active-high.
- enable, input, 1: monitor enable. When low, forces IDLE.
- pulse, input, 1: tick from the upstream timer, normally one cycle high.
- locked, output, 1: high while in LOCKED.
- err_early, output, 1: one-cycle strobe on an early pulse.
- err_timeout, output, 1: one-cycle strobe on a missing pulse.
- last_period, output, CNT_W: most recent measured interval.
- err_count, output, 8: saturating count of error events.

Behaviour:
- Clocking and reset:
  - Clock is `clock`. Reset is `reset`, synchronous, active-high.
  - Reset clears state to IDLE, `gap` = 0, good counter = 0, and all outputs to 0 (`locked`, `err_early`, `err_timeout`, `last_period`, `err_count`).
  - Reset mid-operation aborts immediately. Lock is lost the cycle after the reset edge.
- Interval counter `gap` (CNT_W bits, internal):
  - At an edge with `pulse`=1: `gap` <= 1.
  - Otherwise: `gap` <= `gap`+1, saturating at all-ones.
  - Measured interval at a pulse edge = `gap` value before update. For pulses exactly 12 cycles apart, measured = 12.
- Window and event definitions:
  - in-window: PERIOD-TOL <= measured <= PERIOD+TOL.
  - early: measured < PERIOD-TOL.
  - timeout: `pulse`=0 AND `gap` == PERIOD+TOL at an edge.
  - A pulse at `gap` == PERIOD+TOL is in-window. Pulse wins over timeout; no error.
- `last_period`: loaded with the measured value at every pulse edge outside IDLE. Holds otherwise.
- State machine (all outputs registered; responses visible in the cycle after the deciding edge):
  - IDLE: `gap` is not checked. Pulse (with `enable`=1) -> ACQ, good counter = 0. `last_period` is not updated.
  - ACQ:
    - In-window pulse -> good counter +1. If it reaches LOCK_COUNT -> LOCKED.
    - Early pulse -> `err_early` strobe, good counter = 0, stay in ACQ. The pulse restarts the interval.
    - Timeout -> `err_timeout` strobe, -> IDLE.
  - LOCKED:
    - `locked`=1.
    - In-window pulse -> stay.
    - Early pulse -> `err_early` strobe, -> ACQ, good counter = 0.
    - Timeout -> `err_timeout` strobe, -> IDLE.
- `enable`=0: state -> IDLE and good counter = 0 at the next edge. No error strobes while disabled. `gap` keeps counting. `err_count` and `last_period` hold.
- `err_count`: +1 on each `err_early` or `err_timeout` event. Early and timeout are mutually exclusive in a cycle. Saturates at 255.
- Back-to-back pulses (`pulse` high on consecutive cycles): measured = 1, classified early unless PERIOD-TOL <= 1.
- Latency: first pulse at edge T0 with nominal cadence gives `locked`=1 after edge T0 + LOCK_COUNT*PERIOD.

Test Plan:
1. Defaults; reset 5 cycles, then pulses every 12 cycles from edge T0 -> `locked` rises after edge T0+36; `last_period`=12; no error strobes; `err_count`=0.
2. Locked, then one pulse at interval 9 -> `err_early`=1 for exactly one cycle; `locked` drops; `err_count`=1; `last_period`=9; re-lock 36 cycles after the early pulse.
3. Locked, then pulses stop -> `err_timeout` strobes one cycle after the edge where `gap`=12 with no pulse; state IDLE; `locked`=0. Next pulse starts ACQ without error.
4. TOL=1: intervals 11, 13, 12 -> all accepted and lock after the third. Interval 14 never occurs: timeout fires at `gap`=13. Pulse exactly at `gap`=13 -> accepted, no timeout.
5. Assert `reset` while locked -> all outputs 0 the next cycle. Deassert `enable` while locked -> `locked`=0 next cycle and no strobes during 30 pulseless cycles.
6. Force 260 timeouts (enable pulse to re-enter ACQ each time) -> `err_count` saturates at 255, no wrap.

Source files
------------

// File: rtl/pulse_period_monitor.sv
// Pulse period monitor: measures the interval between upstream timer pulses,
// declares lock after a run of in-window intervals, and flags early/missing pulses.
module pulse_period_monitor #(
  parameter int PERIOD     = 12,
  parameter int TOL        = 0,
  parameter int LOCK_COUNT = 3,
  parameter int CNT_W      = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             pulse,
  output logic             locked,
  output logic             err_early,
  output logic             err_timeout,
  output logic [CNT_W-1:0] last_period,
  output logic [7:0]       err_count
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACQ    = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  localparam int GOOD_W = $clog2(LOCK_COUNT + 1);

  localparam logic [CNT_W-1:0]  WIN_LO    = CNT_W'(PERIOD - TOL);
  localparam logic [CNT_W-1:0]  WIN_HI    = CNT_W'(PERIOD + TOL);
  localparam logic [CNT_W-1:0]  GAP_MAX   = '1;
  localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_COUNT - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] gap_q, gap_d;
  logic [GOOD_W-1:0] good_q, good_d;
  logic             early_q, early_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] last_q, last_d;
  logic [7:0]       err_q, err_d;

  logic is_early, is_in_win, is_timeout;

  // gap_q holds the interval measured so far; a pulse edge sees the full interval.
  always_comb begin
    is_early   = gap_q < WIN_LO;
    is_in_win  = !is_early && (gap_q <= WIN_HI);
    is_timeout = !pulse && (gap_q == WIN_HI);
  end

  // NOTE: every signal gets a default at the top of the block so no path leaves
  // it unassigned; that is what keeps this combinational logic free of latches.
  always_comb begin
    gap_d     = pulse ? CNT_W'(1) : ((gap_q == GAP_MAX) ? gap_q : gap_q + CNT_W'(1));
    state_d   = state_q;
    good_d    = good_q;
    early_d   = 1'b0;
    timeout_d = 1'b0;
    last_d    = last_q;

    if (!enable) begin
      state_d = ST_IDLE;
      good_d  = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (pulse) begin
            state_d = ST_ACQ;
            good_d  = '0;
          end
        end
        ST_ACQ, ST_LOCKED: begin
          if (pulse) begin
            last_d = gap_q;
            if (is_early) begin
              early_d = 1'b1;
              good_d  = '0;
              state_d = ST_ACQ;
            end else if (is_in_win) begin
              if (state_q == ST_ACQ) begin
                good_d = good_q + GOOD_W'(1);
                if (good_q == GOOD_LAST) state_d = ST_LOCKED;
              end
            end else begin
              // Late pulse cannot follow a timeout-free interval; fall back safely.
              state_d = ST_IDLE;
              good_d  = '0;
            end
          end else if (is_timeout) begin
            timeout_d = 1'b1;
            state_d   = ST_IDLE;
            good_d    = '0;
          end
        end
        default: begin
          state_d = ST_IDLE;
          good_d  = '0;
        end
      endcase
    end

    err_d = err_q;
    if ((early_d || timeout_d) && (err_q != 8'hFF)) err_d = err_q + 8'd1;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      gap_q     <= '0;
      good_q    <= '0;
      early_q   <= 1'b0;
      timeout_q <= 1'b0;
      last_q    <= '0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      gap_q     <= gap_d;
      good_q    <= good_d;
      early_q   <= early_d;
      timeout_q <= timeout_d;
      last_q    <= last_d;
      err_q     <= err_d;
    end
  end

  assign locked      = (state_q == ST_LOCKED);
  assign err_early   = early_q;
  assign err_timeout = timeout_q;
  assign last_period = last_q;
  assign err_count   = err_q;

endmodule

// File: tb/tb_pulse_period_monitor.sv
// Bench for pulse_period_monitor: two instances (TOL=0 and TOL=1) share stimulus
// and are compared every cycle against an interval-based reference model.
module tb_pulse_period_monitor;

  logic clock = 1'b0;
  logic reset, enable, pulse;

  logic       a_locked, a_early, a_timeout;
  logic [7:0] a_last, a_err;
  logic       b_locked, b_early, b_timeout;
  logic [7:0] b_last, b_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  pulse_period_monitor #(.PERIOD(12), .TOL(0), .LOCK_COUNT(3), .CNT_W(8)) dut_a (
    .clock(clock), .reset(reset), .enable(enable), .pulse(pulse),
    .locked(a_locked), .err_early(a_early), .err_timeout(a_timeout),
    .last_period(a_last), .err_count(a_err)
  );

  pulse_period_monitor #(.PERIOD(12), .TOL(1), .LOCK_COUNT(3), .CNT_W(8)) dut_b (
    .clock(clock), .reset(reset), .enable(enable), .pulse(pulse),
    .locked(b_locked), .err_early(b_early), .err_timeout(b_timeout),
    .last_period(b_last), .err_count(b_err)
  );

  // Reference model: intervals are edge-count differences between pulses.
  int win_lo [2] = '{12, 11};
  int win_hi [2] = '{12, 13};
  int edge_n = 0;
  int m_ref   [2] = '{0, 0};
  int m_state [2] = '{0, 0};  // 0 idle, 1 acquiring, 2 locked
  int m_good  [2] = '{0, 0};
  int m_last  [2] = '{0, 0};
  int m_err   [2] = '{0, 0};
  bit m_early [2] = '{0, 0};
  bit m_tmo   [2] = '{0, 0};

  always @(posedge clock) begin
    for (int k = 0; k < 2; k++) begin
      int meas;
      meas = edge_n - m_ref[k];
      if (meas > 255) meas = 255;
      m_early[k] = 1'b0;
      m_tmo[k]   = 1'b0;
      if (reset) begin
        m_state[k] = 0; m_good[k] = 0; m_last[k] = 0; m_err[k] = 0;
        m_ref[k]   = edge_n + 1;
      end else begin
        if (!enable) begin
          m_state[k] = 0; m_good[k] = 0;
        end else if (m_state[k] == 0) begin
          if (pulse) begin m_state[k] = 1; m_good[k] = 0; end
        end else if (pulse) begin
          m_last[k] = meas;
          if (meas < win_lo[k]) begin
            m_early[k] = 1'b1; m_good[k] = 0; m_state[k] = 1;
          end else if (meas <= win_hi[k]) begin
            m_good[k]++;
            if (m_good[k] >= 3) m_state[k] = 2;
          end else begin
            m_state[k] = 0; m_good[k] = 0;
          end
        end else if (meas == win_hi[k]) begin
          m_tmo[k] = 1'b1; m_state[k] = 0; m_good[k] = 0;
        end
        if ((m_early[k] || m_tmo[k]) && m_err[k] < 255) m_err[k]++;
        if (pulse) m_ref[k] = edge_n;
      end
    end
    edge_n++;
  end

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic compare_model();
    check("a.locked",  32'(a_locked),  32'(m_state[0] == 2));
    check("a.early",   32'(a_early),   32'(m_early[0]));
    check("a.timeout", 32'(a_timeout), 32'(m_tmo[0]));
    check("a.last",    32'(a_last),    32'(m_last[0]));
    check("a.err",     32'(a_err),     32'(m_err[0]));
    check("b.locked",  32'(b_locked),  32'(m_state[1] == 2));
    check("b.early",   32'(b_early),   32'(m_early[1]));
    check("b.timeout", 32'(b_timeout), 32'(m_tmo[1]));
    check("b.last",    32'(b_last),    32'(m_last[1]));
    check("b.err",     32'(b_err),     32'(m_err[1]));
  endtask

  // Drive pulse for one edge, then sample at the following falling edge.
  task automatic cycle(input logic p);
    pulse = p;
    @(negedge clock);
    compare_model();
  endtask

  task automatic send_interval(input int interval);
    repeat (interval - 1) cycle(1'b0);
    cycle(1'b1);
  endtask

  typedef struct {
    int interval;
    bit a_locked; bit a_early; int a_last; int a_err;
    bit b_locked; bit b_early; int b_last; int b_err;
  } vec_t;

  vec_t vecs [11];

  initial begin
    vecs[0]  = '{12, 0, 0, 12, 0, 0, 0, 12, 0};
    vecs[1]  = '{12, 0, 0, 12, 0, 0, 0, 12, 0};
    vecs[2]  = '{12, 1, 0, 12, 0, 1, 0, 12, 0};
    vecs[3]  = '{12, 1, 0, 12, 0, 1, 0, 12, 0};
    vecs[4]  = '{ 9, 0, 1,  9, 1, 0, 1,  9, 1};
    vecs[5]  = '{12, 0, 0, 12, 1, 0, 0, 12, 1};
    vecs[6]  = '{12, 0, 0, 12, 1, 0, 0, 12, 1};
    vecs[7]  = '{12, 1, 0, 12, 1, 1, 0, 12, 1};
    vecs[8]  = '{11, 0, 1, 11, 2, 1, 0, 11, 1};
    vecs[9]  = '{13, 0, 0, 11, 3, 1, 0, 13, 1};
    vecs[10] = '{12, 0, 0, 12, 3, 1, 0, 12, 1};

    reset = 1'b1; enable = 1'b0; pulse = 1'b0;
    repeat (5) cycle(1'b0);
    check("reset.a_locked", 32'(a_locked), 0);
    check("reset.a_err",    32'(a_err),    0);
    check("reset.b_last",   32'(b_last),   0);

    // Nominal cadence, early pulse, and TOL=1 window edges.
    reset = 1'b0; enable = 1'b1;
    cycle(1'b1);
    for (int i = 0; i < 11; i++) begin
      send_interval(vecs[i].interval);
      check($sformatf("vec%0d.a_locked", i), 32'(a_locked), 32'(vecs[i].a_locked));
      check($sformatf("vec%0d.a_early",  i), 32'(a_early),  32'(vecs[i].a_early));
      check($sformatf("vec%0d.a_last",   i), 32'(a_last),   32'(vecs[i].a_last));
      check($sformatf("vec%0d.a_err",    i), 32'(a_err),    32'(vecs[i].a_err));
      check($sformatf("vec%0d.b_locked", i), 32'(b_locked), 32'(vecs[i].b_locked));
      check($sformatf("vec%0d.b_early",  i), 32'(b_early),  32'(vecs[i].b_early));
      check($sformatf("vec%0d.b_last",   i), 32'(b_last),   32'(vecs[i].b_last));
      check($sformatf("vec%0d.b_err",    i), 32'(b_err),    32'(vecs[i].b_err));
    end

    // Missing pulses: TOL=0 times out at gap 12, TOL=1 at gap 13.
    send_interval(12);
    send_interval(12);
    check("pre_tmo.a_locked", 32'(a_locked), 1);
    repeat (11) cycle(1'b0);
    check("gap11.a_timeout", 32'(a_timeout), 0);
    cycle(1'b0);
    check("gap12.a_timeout", 32'(a_timeout), 1);
    check("gap12.a_locked",  32'(a_locked),  0);
    check("gap12.b_timeout", 32'(b_timeout), 0);
    check("gap12.b_locked",  32'(b_locked),  1);
    cycle(1'b0);
    check("gap13.a_timeout", 32'(a_timeout), 0);
    check("gap13.b_timeout", 32'(b_timeout), 1);
    check("gap13.b_locked",  32'(b_locked),  0);
    cycle(1'b0);
    check("gap14.b_timeout", 32'(b_timeout), 0);
    cycle(1'b1);
    check("restart.a_early", 32'(a_early), 0);
    check("restart.a_err",   32'(a_err),   4);
    check("restart.b_err",   32'(b_err),   2);

    // Reset while locked, then disable while locked.
    repeat (3) send_interval(12);
    check("relock.a_locked", 32'(a_locked), 1);
    reset = 1'b1;
    cycle(1'b0);
    check("midreset.a_locked", 32'(a_locked), 0);
    check("midreset.a_last",   32'(a_last),   0);
    check("midreset.a_err",    32'(a_err),    0);
    check("midreset.b_locked", 32'(b_locked), 0);
    check("midreset.b_err",    32'(b_err),    0);
    reset = 1'b0;
    cycle(1'b1);
    repeat (3) send_interval(12);
    check("relock2.b_locked", 32'(b_locked), 1);
    enable = 1'b0;
    cycle(1'b0);
    check("disable.a_locked", 32'(a_locked), 0);
    check("disable.b_locked", 32'(b_locked), 0);
    for (int i = 0; i < 30; i++) begin
      cycle(1'b0);
      check("disabled.a_strobe", 32'(a_early | a_timeout), 0);
      check("disabled.b_strobe", 32'(b_early | b_timeout), 0);
    end

    // Randomized intervals, enables and occasional resets against the model.
    for (int i = 0; i < 400; i++) begin
      int interval;
      interval = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 20) : $urandom_range(10, 14);
      enable   = ($urandom_range(0, 9) != 0);
      repeat (interval - 1) cycle(1'b0);
      reset = ($urandom_range(0, 99) == 0);
      cycle(1'b1);
      reset = 1'b0;
    end

    // Error tally saturation: 260 forced timeouts per instance.
    enable = 1'b1;
    reset  = 1'b1;
    cycle(1'b0);
    reset  = 1'b0;
    for (int i = 0; i < 260; i++) begin
      cycle(1'b1);
      repeat (13) cycle(1'b0);
    end
    check("sat.a_err", 32'(a_err), 255);
    check("sat.b_err", 32'(b_err), 255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
